// File: rtl/dsp_reg_wb.sv
// -----------------------------------------------------------------------------
// dsp_reg_wb
//
// Write-back stage for the DSP register file. This block owns port B, the
// write port of the 64x32 dual-port RAM. Each cycle it gives the port either
// to an ALU result or to returning load data. The ALU always wins the port.
//
// Loads are tracked in two small FIFOs:
//   - a destination queue, filled when a load is issued;
//   - a data queue, filled when load data returns.
// Both queues pop together when a load is written back. A 64-bit pending
// scoreboard drives the operand-fetch stall.
//
// Ports
//   sys_clk, resetl        clock, asynchronous active-low reset
//   alu_wr/alu_dst/alu_data ALU result request
//   ld_issue/ld_dst         load issued, reserves a destination register
//   ld_done/ld_data         load data returning, in issue order
//   rd_chk_a/rd_chk_b       operand registers currently being fetched
//   nweb/clkb/ab/db         register file port B (nweb active low)
//   stall                   operand hazard (combinational)
//   ld_full                 four loads outstanding
//   pend                    registers with a load still in flight
//   err                     sticky protocol error
// -----------------------------------------------------------------------------
module dsp_reg_wb #(
    parameter int DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic        alu_wr,
    input  logic [5:0]  alu_dst,
    input  logic [31:0] alu_data,
    input  logic        ld_issue,
    input  logic [5:0]  ld_dst,
    input  logic        ld_done,
    input  logic [31:0] ld_data,
    input  logic [5:0]  rd_chk_a,
    input  logic [5:0]  rd_chk_b,
    output logic        nweb,
    output logic        clkb,
    output logic [5:0]  ab,
    output logic [31:0] db,
    output logic        stall,
    output logic        ld_full,
    output logic [63:0] pend,
    output logic        err
);

    // Queue pointers are 2 bits wide and counts are 3 bits wide, so DEPTH must
    // stay at 4.
    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    logic [5:0]  dst_mem_q [DEPTH];
    logic [5:0]  dst_mem_d [DEPTH];
    logic [31:0] dat_mem_q [DEPTH];
    logic [31:0] dat_mem_d [DEPTH];

    logic [1:0]  dwr_ptr_q, dwr_ptr_d;
    logic [1:0]  qwr_ptr_q, qwr_ptr_d;
    logic [1:0]  rd_ptr_q,  rd_ptr_d;
    logic [2:0]  dcnt_q,    dcnt_d;
    logic [2:0]  qcnt_q,    qcnt_d;

    logic        nweb_q, nweb_d;
    logic        clkb_q, clkb_d;
    logic [5:0]  ab_q,   ab_d;
    logic [31:0] db_q,   db_d;
    logic [63:0] pend_q, pend_d;
    logic        ld_full_q, ld_full_d;
    logic        err_q,  err_d;
    // Set while port B is carrying a load write-back. ab_q then holds that
    // load's destination register.
    logic        wb_vld_q, wb_vld_d;

    logic        issue_acc;
    logic        done_acc;
    logic        drain;
    logic        still_owed;
    logic [1:0]  off;

    always_comb begin
        // Acceptance uses only the registered counts. A drain in this cycle
        // therefore does not free a slot for an issue in the same cycle.
        issue_acc = ld_issue && (dcnt_q != FULL_CNT);
        done_acc  = ld_done  && (qcnt_q != dcnt_q);
        drain     = !alu_wr  && (qcnt_q != 3'd0);

        dst_mem_d = dst_mem_q;
        dat_mem_d = dat_mem_q;
        if (issue_acc) dst_mem_d[dwr_ptr_q] = ld_dst;
        if (done_acc)  dat_mem_d[qwr_ptr_q] = ld_data;

        dwr_ptr_d = dwr_ptr_q + {1'b0, issue_acc};
        qwr_ptr_d = qwr_ptr_q + {1'b0, done_acc};
        rd_ptr_d  = rd_ptr_q  + {1'b0, drain};
        dcnt_d    = dcnt_q + {2'b00, issue_acc} - {2'b00, drain};
        qcnt_d    = qcnt_q + {2'b00, done_acc}  - {2'b00, drain};

        nweb_d   = 1'b1;
        clkb_d   = 1'b0;
        ab_d     = ab_q;
        db_d     = db_q;
        wb_vld_d = 1'b0;
        if (alu_wr) begin
            nweb_d = 1'b0;
            clkb_d = 1'b1;
            ab_d   = alu_dst;
            db_d   = alu_data;
        end else if (drain) begin
            nweb_d   = 1'b0;
            clkb_d   = 1'b1;
            ab_d     = dst_mem_q[rd_ptr_q];
            db_d     = dat_mem_q[rd_ptr_q];
            wb_vld_d = 1'b1;
        end

        // A register stays pending while any queued load, or a load being
        // pushed this cycle, still targets it. Entries that are drained but
        // not yet written are still in the registered queue, so they count.
        still_owed = issue_acc && (ld_dst == ab_q);
        off        = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            off = 2'(i) - rd_ptr_q;
            if (({1'b0, off} < dcnt_q) && (dst_mem_q[i] == ab_q)) begin
                still_owed = 1'b1;
            end
        end

        // Clear at the edge where the RAM takes the load data. If a set hits
        // the same bit, the set wins.
        pend_d = pend_q;
        if (wb_vld_q && !still_owed) pend_d[ab_q] = 1'b0;
        if (issue_acc)               pend_d[ld_dst] = 1'b1;

        ld_full_d = (dcnt_d == FULL_CNT);
        err_d     = err_q | (ld_issue && !issue_acc) | (ld_done && !done_acc);
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            for (int i = 0; i < DEPTH; i++) begin
                dst_mem_q[i] <= '0;
                dat_mem_q[i] <= '0;
            end
            dwr_ptr_q <= '0;
            qwr_ptr_q <= '0;
            rd_ptr_q  <= '0;
            dcnt_q    <= '0;
            qcnt_q    <= '0;
            nweb_q    <= 1'b1;
            clkb_q    <= 1'b0;
            ab_q      <= '0;
            db_q      <= '0;
            pend_q    <= '0;
            ld_full_q <= 1'b0;
            err_q     <= 1'b0;
            wb_vld_q  <= 1'b0;
        end else begin
            dst_mem_q <= dst_mem_d;
            dat_mem_q <= dat_mem_d;
            dwr_ptr_q <= dwr_ptr_d;
            qwr_ptr_q <= qwr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            dcnt_q    <= dcnt_d;
            qcnt_q    <= qcnt_d;
            nweb_q    <= nweb_d;
            clkb_q    <= clkb_d;
            ab_q      <= ab_d;
            db_q      <= db_d;
            pend_q    <= pend_d;
            ld_full_q <= ld_full_d;
            err_q     <= err_d;
            wb_vld_q  <= wb_vld_d;
        end
    end

    assign nweb    = nweb_q;
    assign clkb    = clkb_q;
    assign ab      = ab_q;
    assign db      = db_q;
    assign pend    = pend_q;
    assign ld_full = ld_full_q;
    assign err     = err_q;
    assign stall   = pend_q[rd_chk_a] | pend_q[rd_chk_b];

endmodule

// File: tb/tb_dsp_reg_wb.sv
// -----------------------------------------------------------------------------
// Testbench for dsp_reg_wb.
//
// The reference model tracks the load queues as plain SystemVerilog queues.
// It counts in-flight loads for each register; a register is pending while
// that count is above zero. A small RAM array records what reaches port B.
// -----------------------------------------------------------------------------
module tb_dsp_reg_wb;

    logic        sys_clk  = 1'b0;
    logic        resetl   = 1'b0;
    logic        alu_wr   = 1'b0;
    logic [5:0]  alu_dst  = '0;
    logic [31:0] alu_data = '0;
    logic        ld_issue = 1'b0;
    logic [5:0]  ld_dst   = '0;
    logic        ld_done  = 1'b0;
    logic [31:0] ld_data  = '0;
    logic [5:0]  rd_chk_a = '0;
    logic [5:0]  rd_chk_b = '0;
    logic        nweb, clkb, stall, ld_full, err;
    logic [5:0]  ab;
    logic [31:0] db;
    logic [63:0] pend;

    always #5 sys_clk = ~sys_clk;

    dsp_reg_wb #(.DEPTH(4)) dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .alu_wr  (alu_wr),
        .alu_dst (alu_dst),
        .alu_data(alu_data),
        .ld_issue(ld_issue),
        .ld_dst  (ld_dst),
        .ld_done (ld_done),
        .ld_data (ld_data),
        .rd_chk_a(rd_chk_a),
        .rd_chk_b(rd_chk_b),
        .nweb    (nweb),
        .clkb    (clkb),
        .ab      (ab),
        .db      (db),
        .stall   (stall),
        .ld_full (ld_full),
        .pend    (pend),
        .err     (err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [5:0]  m_dq[$];
    logic [31:0] m_datq[$];
    int          cnt [64];
    logic        m_nweb   = 1'b1;
    logic        m_clkb   = 1'b0;
    logic [5:0]  m_ab     = '0;
    logic [31:0] m_db     = '0;
    logic        m_err    = 1'b0;
    logic        m_full   = 1'b0;
    logic        m_wb_vld = 1'b0;

    function automatic logic [63:0] model_pend();
        logic [63:0] p;
        for (int i = 0; i < 64; i++) p[i] = (cnt[i] > 0);
        return p;
    endfunction

    always @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            m_dq.delete();
            m_datq.delete();
            for (int i = 0; i < 64; i++) cnt[i] = 0;
            m_nweb = 1'b1; m_clkb = 1'b0; m_ab = '0; m_db = '0;
            m_err = 1'b0; m_full = 1'b0; m_wb_vld = 1'b0;
        end else begin
            int  nd, nq;
            bit  iss, don;
            nd  = m_dq.size();
            nq  = m_datq.size();
            iss = ld_issue && (nd < 4);
            don = ld_done && (nq < nd);
            if (ld_issue && !iss) m_err = 1'b1;
            if (ld_done && !don)  m_err = 1'b1;
            // The load write that was on the port this cycle reaches the RAM now.
            if (m_wb_vld) cnt[m_ab] = cnt[m_ab] - 1;
            m_wb_vld = 1'b0;
            if (alu_wr) begin
                m_nweb = 1'b0; m_clkb = 1'b1; m_ab = alu_dst; m_db = alu_data;
            end else if (nq > 0) begin
                m_nweb = 1'b0; m_clkb = 1'b1;
                m_ab = m_dq.pop_front();
                m_db = m_datq.pop_front();
                m_wb_vld = 1'b1;
            end else begin
                m_nweb = 1'b1; m_clkb = 1'b0;
            end
            if (iss) begin
                m_dq.push_back(ld_dst);
                cnt[ld_dst] = cnt[ld_dst] + 1;
            end
            if (don) m_datq.push_back(ld_data);
            m_full = (m_dq.size() == 4);
        end
    end

    // ---------------- register file port B as seen by the RAM ----------------
    logic [31:0] ram [64];
    logic        s_we = 1'b0;
    logic [5:0]  s_ab = '0;
    logic [31:0] s_db = '0;

    always @(negedge sys_clk) begin
        s_we = (nweb == 1'b0) && (clkb == 1'b1);
        s_ab = ab;
        s_db = db;
    end
    always @(posedge sys_clk) if (s_we) ram[s_ab] = s_db;

    // ---------------- per-cycle comparison ----------------
    always @(negedge sys_clk) begin
        if (resetl) begin
            logic [63:0] mp;
            mp = model_pend();
            chk("cyc_nweb", nweb, m_nweb);
            chk("cyc_clkb", clkb, m_clkb);
            chk("cyc_ab", ab, m_ab);
            chk("cyc_db", db, m_db);
            chk("cyc_pend", pend, mp);
            chk("cyc_stall", stall, mp[rd_chk_a] | mp[rd_chk_b]);
            chk("cyc_ld_full", ld_full, m_full);
            chk("cyc_err", err, m_err);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] r);
        ld_issue = 1'b1; ld_dst = r;
        tick();
        ld_issue = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] mp;
        resetl = 1'b0;
        repeat (3) tick();
        resetl = 1'b1;
        chk("rst_nweb", nweb, 1'b1);
        chk("rst_clkb", clkb, 1'b0);
        chk("rst_pend", pend, 64'h0);
        chk("rst_ld_full", ld_full, 1'b0);
        chk("rst_err", err, 1'b0);
        tick();

        // ALU write to r5
        alu_wr = 1'b1; alu_dst = 6'd5; alu_data = 32'h1234_5678;
        tick();
        alu_wr = 1'b0;
        chk("alu_ab", ab, 6'd5);
        chk("alu_db", db, 32'h1234_5678);
        chk("alu_nweb", nweb, 1'b0);
        chk("model_alu_ab", m_ab, 6'd5);
        tick();
        chk("alu_ram_r5", ram[5], 32'h1234_5678);

        // Load hazard on r9
        rd_chk_a = 6'd9;
        issue(6'd9);
        chk("haz_pend9", pend[9], 1'b1);
        chk("haz_stall", stall, 1'b1);
        mp = model_pend();
        chk("model_pend9", mp[9], 1'b1);
        ld_done = 1'b1; ld_data = 32'hCAFE_F00D;
        tick();
        ld_done = 1'b0;
        tick();
        chk("haz_wb_ab", ab, 6'd9);
        chk("haz_wb_db", db, 32'hCAFE_F00D);
        chk("haz_wb_nweb", nweb, 1'b0);
        chk("haz_stall_n2", stall, 1'b1);
        tick();
        chk("haz_stall_n3", stall, 1'b0);
        chk("haz_ram_r9", ram[9], 32'hCAFE_F00D);
        rd_chk_a = 6'd0;

        // Contention: two loads return while the ALU holds the port for 3 cycles
        issue(6'd1);
        issue(6'd2);
        ld_done = 1'b1; ld_data = 32'h1111_0001; alu_wr = 1'b1; alu_dst = 6'd20; alu_data = 32'hA20;
        tick();
        chk("cont_alu0", ab, 6'd20);
        ld_data = 32'h2222_0002; alu_dst = 6'd21; alu_data = 32'hA21;
        tick();
        chk("cont_alu1", ab, 6'd21);
        ld_done = 1'b0; alu_dst = 6'd22; alu_data = 32'hA22;
        tick();
        chk("cont_alu2", ab, 6'd22);
        alu_wr = 1'b0;
        tick();
        chk("cont_r1_ab", ab, 6'd1);
        chk("cont_r1_db", db, 32'h1111_0001);
        chk("cont_pend_12", pend[2:1], 2'b11);
        tick();
        chk("cont_r2_ab", ab, 6'd2);
        chk("cont_r2_db", db, 32'h2222_0002);
        chk("cont_pend_12b", pend[2:1], 2'b10);
        tick();
        chk("cont_pend_12c", pend[2:1], 2'b00);
        chk("cont_idle_nweb", nweb, 1'b1);

        // Full and wrap: 3 rounds of 4 loads
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) issue(6'(10 + 4 * r + k));
            chk("full_ld_full", ld_full, 1'b1);
            if (r == 0) begin
                issue(6'd40);
                chk("full_err", err, 1'b1);
                chk("full_pend40", pend[40], 1'b0);
                chk("full_still", ld_full, 1'b1);
            end
            for (int k = 0; k < 4; k++) begin
                ld_done = 1'b1; ld_data = 32'hA000_0000 + 32'(r * 16 + k);
                tick();
            end
            ld_done = 1'b0;
            repeat (3) tick();
            for (int k = 0; k < 4; k++)
                chk("wrap_ram", ram[10 + 4 * r + k], 32'hA000_0000 + 32'(r * 16 + k));
            chk("wrap_not_full", ld_full, 1'b0);
        end

        // Duplicate destination r7
        issue(6'd7);
        issue(6'd7);
        ld_done = 1'b1; ld_data = 32'hD1D1_0001;
        tick();
        ld_data = 32'hD2D2_0002;
        tick();
        ld_done = 1'b0;
        tick();
        chk("dup_pend7_mid", pend[7], 1'b1);
        chk("dup_ab", ab, 6'd7);
        chk("dup_db", db, 32'hD2D2_0002);
        tick();
        chk("dup_pend7_end", pend[7], 1'b0);
        chk("dup_ram_r7", ram[7], 32'hD2D2_0002);

        // Load lost at reset, then a spurious ld_done
        issue(6'd3);
        resetl = 1'b0;
        tick();
        resetl = 1'b1;
        chk("lost_pend", pend, 64'h0);
        chk("lost_err_clr", err, 1'b0);
        ld_done = 1'b1; ld_data = 32'hBAD0_BAD0;
        tick();
        ld_done = 1'b0;
        chk("spur_err", err, 1'b1);
        chk("spur_nweb", nweb, 1'b1);
        tick();
        chk("spur_nweb2", nweb, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                alu_wr = 1'b0; ld_issue = 1'b0; ld_done = 1'b0;
                resetl = 1'b0;
                tick();
                tick();
                resetl = 1'b1;
            end
            alu_wr   = ($urandom_range(0, 99) < 35);
            alu_dst  = 6'($urandom_range(0, 63));
            alu_data = $urandom;
            ld_issue = ($urandom_range(0, 99) < 40) &&
                       ((m_dq.size() < 4) || ($urandom_range(0, 99) < 3));
            ld_dst   = 6'($urandom_range(0, 7));
            ld_done  = ($urandom_range(0, 99) < 45) &&
                       ((m_datq.size() < m_dq.size()) || ($urandom_range(0, 99) < 2));
            ld_data  = $urandom;
            rd_chk_a = 6'($urandom_range(0, 9));
            rd_chk_b = 6'($urandom_range(0, 63));
            tick();
        end
        alu_wr = 1'b0; ld_issue = 1'b0; ld_done = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
